// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
// Package : input_cond_pkg
// Brief   : Shared constants and helpers for the button/switch input conditioner
// Rev     : 1.0  initial release
// ============================================================================
package input_cond_pkg;

    // 1 ms of stability at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE = 50000;
    localparam int SIM_DEBOUNCE     = 4;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : input_cond_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module : debounce_channel
// Brief  : One bit of 2-FF sync, stability counter, debounced level, edge pulses
// Rev    : 1.0  initial release
// ============================================================================
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rise_next
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    logic             w_level_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_rise_next;
    logic             w_fall_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
        end
    end

    // Any sample agreeing with the current level restarts qualification
    always_comb begin
        w_level_next = r_level;
        w_cnt_next   = '0;
        if (r_s2 != r_level) begin
            if (r_cnt == CNT_LAST) begin
                w_level_next = r_s2;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_rise_next =  w_level_next & ~r_level;
    assign w_fall_next = ~w_level_next &  r_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
            r_fall  <= w_fall_next;
        end
    end

    assign level     = r_level;
    assign rise      = r_rise;
    assign fall      = r_fall;
    assign rise_next = w_rise_next;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module : input_conditioner
// Brief  : N debounced, edge-detected inputs plus a direction toggle on channel 0
// Rev    : 1.0  initial release
// ============================================================================
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         dir_toggle
);

    logic [N-1:0] w_rise_next;
    logic         w_unused_rise_next;
    logic         r_dir_toggle;

    generate
        for (genvar g = 0; g < N; g++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .raw_in    (raw_in[g]),
                .level     (level[g]),
                .rise      (rise[g]),
                .fall      (fall[g]),
                .rise_next (w_rise_next[g])
            );
        end
    endgenerate

    // Only channel 0's early rise steers direction; other channels' are spare
    assign w_unused_rise_next = &{1'b0, w_rise_next};

    // Toggling from the next-state keeps dir aligned with the rise[0] pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir_toggle <= 1'b0;
        end else if (w_rise_next[0]) begin
            r_dir_toggle <= ~r_dir_toggle;
        end
    end

    assign dir_toggle = r_dir_toggle;

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module : tb_input_conditioner
// Brief  : Random + directed stimulus, queue scoreboard against a window model
// Rev    : 1.0  initial release
// ============================================================================
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int N = 2;
    localparam int D = SIM_DEBOUNCE;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         dir_toggle;

    input_conditioner #(
        .N               (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .level      (level),
        .rise       (rise),
        .fall       (fall),
        .dir_toggle (dir_toggle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         dir;
    } exp_t;

    exp_t         expq[$];
    logic [N-1:0] syncq[$];   // raw samples still travelling through the synchroniser
    logic [N-1:0] window[$];  // last D synchronised samples
    logic [N-1:0] m_level;
    int           m_rises;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_clear();
        syncq.delete();
        syncq.push_back('0);
        syncq.push_back('0);
        window.delete();
        m_level = '0;
        m_rises = 0;
        expq.delete();
    endfunction

    always @(negedge reset) model_clear();

    // A level flips once the last D synchronised samples all disagree with it
    always @(posedge clk) begin : model
        logic [N-1:0] s2_now;
        logic [N-1:0] new_level;
        logic         all_diff;
        exp_t         e;
        if (!reset) begin
            expq.push_back('0);
        end else begin
            s2_now = syncq.pop_front();
            syncq.push_back(raw_in);
            window.push_back(s2_now);
            if (window.size() > D) void'(window.pop_front());
            new_level = m_level;
            for (int c = 0; c < N; c++) begin
                all_diff = (window.size() == D);
                foreach (window[i]) if (window[i][c] == m_level[c]) all_diff = 1'b0;
                if (all_diff) new_level[c] = ~m_level[c];
            end
            e.level = new_level;
            e.rise  = new_level & ~m_level;
            e.fall  = ~new_level & m_level;
            if (e.rise[0]) m_rises++;
            e.dir   = m_rises[0];
            m_level = new_level;
            expq.push_back(e);
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("level", 32'(level), 32'(e.level));
            chk("rise",  32'(rise),  32'(e.rise));
            chk("fall",  32'(fall),  32'(e.fall));
            chk("dir",   32'(dir_toggle), 32'(e.dir));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        model_clear();
        reset  = 1'b0;
        raw_in = '0;
        tick(3);
        reset = 1'b1;

        // Clean press on channel 0: level appears on the 6th edge
        raw_in[0] = 1'b1;
        tick(5);
        chk("press_level_edge5", 32'(level[0]), 32'd0);
        tick(1);
        chk("press_level_edge6", 32'(level[0]), 32'd1);
        chk("press_rise_edge6",  32'(rise[0]),  32'd1);
        tick(1);
        chk("press_rise_edge7",  32'(rise[0]),  32'd0);
        chk("press_dir",         32'(dir_toggle), 32'd1);
        chk("press_ch1_idle",    32'(level[1]), 32'd0);

        // Asynchronous reset with no clock edge in between
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_level", 32'(level), 32'd0);
        chk("async_rise",  32'(rise),  32'd0);
        chk("async_fall",  32'(fall),  32'd0);
        chk("async_dir",   32'(dir_toggle), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(10);

        // Short glitch on channel 1 is discarded
        raw_in[1] = 1'b1;
        tick(3);
        raw_in[1] = 1'b0;
        tick(10);

        // Bounce on channel 0 then hold high
        raw_in[0] = 1'b0;
        tick(10);
        for (int k = 0; k < 5; k++) begin
            raw_in[0] = ~k[0];
            tick(2);
        end
        tick(12);

        // Two press/release cycles on channel 0
        for (int k = 0; k < 4; k++) begin
            raw_in[0] = k[0];
            tick(9);
        end

        // Reset mid-debounce with raw held high
        raw_in[0] = 1'b0;
        tick(10);
        raw_in[0] = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(10);

        // Random stimulus with occasional asynchronous resets
        for (int k = 0; k < 300; k++) begin
            raw_in = N'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                tick($urandom_range(1, 3));
                reset = 1'b1;
            end
            tick($urandom_range(1, 8));
        end

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_input_conditioner
`default_nettype wire
